// File: rtl/sync_debounce_edge.sv
// Input conditioner: synchronises a raw async level, debounces it with a counter FSM and
// emits a clean registered level plus one-cycle rise/fall pulses.
module sync_debounce_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic n_res,
  input  logic d_in,
  input  logic en,
  output logic q_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StStableLo,
    StChkHi,
    StStableHi,
    StChkLo
  } state_e;

  localparam state_e StReset = RESET_VAL ? StStableHi : StStableLo;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchroniser runs regardless of en so the FSM always sees a fresh, metastability-safe level.
  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      state_q <= StReset;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        StStableLo: begin
          if (s) begin
            state_d = StChkHi;
            cnt_d   = CntOne;
          end
        end
        StChkHi: begin
          if (!s) begin
            state_d = StStableLo;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StStableHi;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StStableHi: begin
          if (!s) begin
            state_d = StChkLo;
            cnt_d   = CntOne;
          end
        end
        StChkLo: begin
          if (s) begin
            state_d = StStableHi;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StStableLo;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StReset;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign q_out      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge with default parameters: expected {q_out, rise, fall} per edge
// are queued as stimulus is driven and popped when the outputs are sampled after the edge.
module tb_sync_debounce_edge;

  logic clk;
  logic n_res;
  logic d_in;
  logic en;
  logic q_out;
  logic rise_pulse;
  logic fall_pulse;

  logic [2:0] exp_q[$];
  int unsigned n_cmp;
  int unsigned n_err;

  sync_debounce_edge #(
    .SYNC_STAGES(2),
    .DEB_CYCLES (4),
    .RESET_VAL  (1'b0)
  ) u_dut (
    .clk       (clk),
    .n_res     (n_res),
    .d_in      (d_in),
    .en        (en),
    .q_out     (q_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {q,rise,fall}=%b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [2:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {q_out, rise_pulse, fall_pulse}, exp);
    end
  endtask

  // Called at a falling edge; drives inputs for the next rising edge and checks after it.
  task automatic step(input string tag, input int k, input logic d, input logic e,
                      input logic [2:0] exp);
    d_in = d;
    en   = e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    pop_check($sformatf("%s[%0d]", tag, k));
    @(negedge clk);
  endtask

  // Held level from a stable state: commit lands on edge 6.
  task automatic rise_run(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      step(tag, k, 1'b1, 1'b1, (k < 6) ? 3'b000 : (k == 6) ? 3'b110 : 3'b100);
    end
  endtask

  task automatic fall_run(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      step(tag, k, 1'b0, 1'b1, (k < 6) ? 3'b100 : (k == 6) ? 3'b001 : 3'b000);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_res = 1'b0;
    d_in  = 1'b1;
    en    = 1'b1;

    // Reset asserted mid-cycle must clear outputs before the next edge.
    #3 n_res = 1'b1;
    #20 n_res = 1'b0;
    exp_q.push_back(3'b000);
    #1 pop_check("t1_async_rst");
    @(negedge clk);
    n_res = 1'b1;
    d_in  = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) step("idle", k, 1'b0, 1'b1, 3'b000);

    rise_run("t2_rise", 10);
    fall_run("t4_fall", 10);

    // Three-cycle high never reaches q_out.
    for (int k = 1; k <= 10; k++) step("t3_glitch_hi", k, (k <= 3), 1'b1, 3'b000);

    rise_run("t4_rerise", 10);
    for (int k = 1; k <= 9; k++) step("t4_glitch_lo", k, (k != 1), 1'b1, 3'b100);
    for (int k = 1; k <= 12; k++) step("toggle", k, k[0], 1'b1, 3'b100);
    for (int k = 1; k <= 4; k++) step("hold_hi", k, 1'b1, 1'b1, 3'b100);

    // Low bounce that starts and ends inside an en=0 window is not seen.
    for (int k = 1; k <= 8; k++) step("en_bounce", k, (k > 3), 1'b0, 3'b100);
    for (int k = 1; k <= 6; k++) step("en_bounce_post", k, 1'b1, 1'b1, 3'b100);

    fall_run("fall2", 10);

    // en low on edges 4 and 5 delays the commit to edge 8.
    for (int k = 1; k <= 12; k++) begin
      step("t5_en_gap", k, 1'b1, !(k == 4 || k == 5),
           (k < 8) ? 3'b000 : (k == 8) ? 3'b110 : 3'b100);
    end

    // Async reset while high clears q_out immediately.
    n_res = 1'b0;
    exp_q.push_back(3'b000);
    #1 pop_check("async_rst_hi");
    d_in = 1'b0;
    @(negedge clk);
    n_res = 1'b1;
    for (int k = 1; k <= 3; k++) step("post_rst", k, 1'b0, 1'b1, 3'b000);

    // Reset during CHK_HI discards the pending count.
    for (int k = 1; k <= 3; k++) step("t6_pre", k, 1'b1, 1'b1, 3'b000);
    n_res = 1'b0;
    step("t6_in_rst", 4, 1'b1, 1'b1, 3'b000);
    step("t6_in_rst", 5, 1'b1, 1'b1, 3'b000);
    n_res = 1'b1;
    rise_run("t6_post", 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
